wb_port_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two requesters:
  - the in-order pipeline writeback slot (MEM/WB fields);
  - an out-of-band long-latency unit (multiply/divide, MDU) returning results via valid/ready.
- Pipeline has default priority. MDU results are buffered in a small FIFO.
- A starvation counter forces an MDU grant and stalls the pipeline for one cycle.
- Sits between the MEM/WB boundary and the register file; also performs the writeback result mux.

---
 rtl/wb_port_arbiter_pkg.sv | 33 +++
 rtl/wb_mdu_fifo.sv | 43 ++++
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared types and writeback result mux for the write-port arbiter
package wb_port_arbiter_pkg;

  typedef logic [31:0] data_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'd0,
    RESULT_MEM = 2'd1,
    RESULT_PC4 = 2'd2
  } result_src_t;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    reg_addr_t rd;
    data_t     data;
  } wb_entry_t;

  // Unused encoding falls back to the ALU result.
  function automatic data_t wb_result_mux(input result_src_t src, input data_t alu,
                                          input data_t mem, input data_t pc4);
    case (src)
      RESULT_MEM: return mem;
      RESULT_PC4: return pc4;
      default:    return alu;
    endcase
  endfunction

endpackage

// File: rtl/wb_mdu_fifo.sv
// rtl/wb_mdu_fifo.sv - MDU result buffer, pointers carry an extra wrap bit to tell full from empty
module wb_mdu_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  wb_entry_t     mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter (pipeline vs. buffered MDU results)
// Optional same-cycle MDU bypass into an empty buffer: define WB_ARB_BYPASS_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_reg_write,
  input  result_src_t wb_result_src,
  input  logic [31:0] wb_alu_result,
  input  logic [31:0] wb_read_data,
  input  logic [31:0] wb_pc_plus_4,
  input  logic [4:0]  wb_rd,
  output logic        wb_stall,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] cnt_inc;
  logic          fifo_full;
  logic          fifo_empty;
  wb_entry_t     head;
  wb_entry_t     push_entry;
  logic          pipe_req;
  logic          mdu_req;
  logic          accept;
  logic          push;
  logic          grant_pipe;
  logic          grant_mdu;
  logic          bypass;
  reg_addr_t     gnt_rd;
  data_t         gnt_data;

  assign pipe_req   = wb_valid & wb_reg_write;
  assign mdu_req    = !fifo_empty;
  assign mdu_ready  = !reset && !fifo_full;
  assign accept     = mdu_valid & mdu_ready;
  assign push       = accept & !bypass;
  assign push_entry = '{rd: mdu_rd, data: mdu_data};
  assign wb_stall   = !reset && (state == ARB_FORCE) && pipe_req;
  assign cnt_inc    = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;

  always_comb begin
    grant_pipe = 1'b0;
    grant_mdu  = 1'b0;
    bypass     = 1'b0;
    if (state == ARB_FORCE) grant_mdu = mdu_req;
    else if (pipe_req)      grant_pipe = 1'b1;
    else if (mdu_req)       grant_mdu = 1'b1;
`ifdef WB_ARB_BYPASS_EN
    else if (accept)        bypass = 1'b1;
`endif

    gnt_rd   = head.rd;
    gnt_data = head.data;
    if (grant_pipe) begin
      gnt_rd   = wb_rd;
      gnt_data = wb_result_mux(wb_result_src, wb_alu_result, wb_read_data, wb_pc_plus_4);
    end else if (bypass) begin
      gnt_rd   = mdu_rd;
      gnt_data = mdu_data;
    end
  end

  wb_mdu_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .entry (push_entry),
    .pop   (grant_mdu),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      rf_we <= 1'b0;
      // x0 grants still consume the request; they just never write.
      if (grant_pipe || grant_mdu || bypass) begin
        rf_we    <= (gnt_rd != '0);
        rf_waddr <= gnt_rd;
        rf_wdata <= gnt_data;
      end

      case (state)
        ARB_FORCE: state <= ARB_NORMAL;
        default: begin
          if (pipe_req && mdu_req) begin
            starve_cnt <= cnt_inc;
            if (cnt_inc == LIMIT) state <= ARB_FORCE;
          end
        end
      endcase

      if (grant_mdu || bypass) starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized and directed bench for wb_port_arbiter against a queue model
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_reg_write;
  result_src_t wb_result_src;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus_4;
  logic [4:0]  wb_rd;
  logic        wb_stall;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_result_src(wb_result_src), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc_plus_4(wb_pc_plus_4), .wb_rd(wb_rd), .wb_stall(wb_stall), .mdu_valid(mdu_valid),
    .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          starve;
  bit          force_next;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        e_stall, e_ready, a_stall, a_ready;
  logic [39:0] act_v, exp_v;

  // Reference: buffered results in a queue, denial count as an int, one-shot forced grant.
  task automatic model_step();
    bit preq, mreq, acc, gp, gm, byp;
    ent_t h;
    logic [31:0] pv;
    preq    = wb_valid && wb_reg_write;
    mreq    = q.size() != 0;
    e_ready = !reset && (q.size() < DEPTH);
    e_stall = 1'b0;
    if (reset) begin
      q.delete();
      starve = 0; force_next = 0;
      m_we = 0; m_addr = 0; m_data = 0;
      return;
    end
    acc = mdu_valid && e_ready;
    gp = 0; gm = 0; byp = 0;
    if (force_next) begin
      gm = mreq;
      e_stall = preq;
    end else if (preq) gp = 1;
    else if (mreq) gm = 1;
`ifdef WB_ARB_BYPASS_EN
    else if (acc) byp = 1;
`endif
    if (force_next) force_next = 0;
    else if (preq && mreq) begin
      starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      if (starve == LIMIT) force_next = 1;
    end
    if (gm || byp) starve = 0;

    case (wb_result_src)
      RESULT_MEM: pv = wb_read_data;
      RESULT_PC4: pv = wb_pc_plus_4;
      default:    pv = wb_alu_result;
    endcase
    m_we = 0;
    if (gp) begin
      m_we = (wb_rd != 0); m_addr = wb_rd; m_data = pv;
    end else if (gm) begin
      h = q.pop_front();
      m_we = (h.rd != 0); m_addr = h.rd; m_data = h.data;
    end else if (byp) begin
      m_we = (mdu_rd != 0); m_addr = mdu_rd; m_data = mdu_data;
    end
    if (acc && !byp) q.push_back('{mdu_rd, mdu_data});
  endtask

  task automatic cycle();
    #1;
    model_step();
    a_stall = wb_stall;
    a_ready = mdu_ready;
    @(posedge clk);
    #1;
    act_v = {a_stall, a_ready, rf_we, rf_waddr, rf_wdata};
    exp_v = {e_stall, e_ready, m_we, m_addr, m_data};
  endtask

  task automatic idle();
    reset = 0; wb_valid = 0; wb_reg_write = 0; wb_result_src = RESULT_ALU;
    wb_alu_result = 0; wb_read_data = 0; wb_pc_plus_4 = 0; wb_rd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    cycle();
    checks++;
    if (act_v !== exp_v) begin errors++; $display("FAIL reset_model: got %h exp %h", act_v, exp_v); end
    checks++;
    if ({a_ready, a_stall, rf_we, rf_waddr, rf_wdata} !== 40'h0) begin
      errors++; $display("FAIL reset_state: got %h exp 0", {a_ready, a_stall, rf_we, rf_waddr, rf_wdata});
    end
    reset = 0;
    cycle();
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", a_ready); end
  endtask

  task automatic test_pipeline_only();
    idle();
    wb_valid = 1; wb_reg_write = 1; wb_rd = 5; wb_alu_result = 32'h1234;
    wb_read_data = $urandom; wb_pc_plus_4 = $urandom;
    cycle();
    checks++;
    if ({a_stall, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL pipe_alu: got %h exp %h", {a_stall, rf_we, rf_waddr, rf_wdata},
                         {1'b0, 1'b1, 5'd5, 32'h1234});
    end
    for (int c = 0; c < 4; c++) begin
      wb_result_src = result_src_t'(c % 3); wb_rd = 5'($urandom_range(1, 31));
      wb_alu_result = $urandom; wb_read_data = $urandom; wb_pc_plus_4 = $urandom;
      cycle();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL pipe_mux c%0d: got %h exp %h", c, act_v, exp_v); end
    end
    idle();
    cycle();
  endtask

  task automatic test_mdu_only();
    int lat;
    logic [36:0] first;
    idle();
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'hDEAD;
    lat = -1; first = '0;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      mdu_valid = 0;
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL mdu_model c%0d: got %h exp %h", c, act_v, exp_v); end
      if (rf_we && lat < 0) begin lat = c; first = {rf_waddr, rf_wdata}; end
    end
    checks++;
    if (lat != EXP_LAT || first !== {5'd7, 32'hDEAD}) begin
      errors++; $display("FAIL mdu_latency: got lat=%0d %h exp lat=%0d %h", lat, first, EXP_LAT, {5'd7, 32'hDEAD});
    end
  endtask

  task automatic test_starvation();
    int k, first_stall;
    logic [4:0] seen[$];
    logic [4:0] exp_seq[9];
    bit bad;
    exp_seq = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd7, 5'd15, 5'd16, 5'd17};
    idle();
    wb_valid = 1; wb_reg_write = 1; k = 0; first_stall = -1;
    for (int c = 0; c < 9; c++) begin
      wb_rd = 5'(10 + k); wb_alu_result = 32'h1000 + 32'(k);
      mdu_valid = (c == 0); mdu_rd = 7; mdu_data = 32'hBEEF;
      cycle();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL starve_model c%0d: got %h exp %h", c, act_v, exp_v); end
      if (a_stall && first_stall < 0) first_stall = c;
      if (rf_we) seen.push_back(rf_waddr);
      if (!a_stall) k++;
    end
    checks++;
    if (first_stall != 5) begin errors++; $display("FAIL starve_stall_cycle: got %0d exp 5", first_stall); end
    bad = (seen.size() != 9);
    for (int i = 0; i < 9 && !bad; i++) if (seen[i] != exp_seq[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL starve_order: got %p exp %p", seen, exp_seq); end
    idle();
    cycle();
  endtask

  task automatic test_fifo_full();
    int k, acc_cnt;
    int acc_cyc[$], stall_cyc[$];
    logic [4:0] mseq[$];
    logic rdy2;
    idle();
    wb_valid = 1; wb_reg_write = 1; k = 0; acc_cnt = 0; rdy2 = 1'bx;
    for (int c = 0; c < 17; c++) begin
      wb_rd = 5'(1 + k % 15); wb_alu_result = 32'(k);
      mdu_valid = (acc_cnt < 3); mdu_rd = 5'(20 + acc_cnt); mdu_data = 32'hA000 + 32'(acc_cnt);
      cycle();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL full_model c%0d: got %h exp %h", c, act_v, exp_v); end
      if (c == 2) rdy2 = a_ready;
      if (mdu_valid && a_ready) begin acc_cyc.push_back(c); acc_cnt++; end
      if (a_stall) stall_cyc.push_back(c); else k++;
      if (rf_we && rf_waddr >= 20) mseq.push_back(rf_waddr);
    end
    checks++;
    if (rdy2 !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", rdy2); end
    checks++;
    if (acc_cyc.size() != 3 || acc_cyc[0] != 0 || acc_cyc[1] != 1 || acc_cyc[2] != 6) begin
      errors++; $display("FAIL full_accepts: got %p exp 0 1 6", acc_cyc);
    end
    checks++;
    if (stall_cyc.size() != 3 || stall_cyc[0] != 5 || stall_cyc[1] != 10 || stall_cyc[2] != 15) begin
      errors++; $display("FAIL full_stalls: got %p exp 5 10 15", stall_cyc);
    end
    checks++;
    if (mseq.size() != 3 || mseq[0] != 20 || mseq[1] != 21 || mseq[2] != 22) begin
      errors++; $display("FAIL full_order: got %p exp 20 21 22", mseq);
    end
    idle();
    cycle();
  endtask

  task automatic test_x0();
    logic we_seen;
    int lat;
    idle();
    wb_valid = 1; wb_reg_write = 1; wb_rd = 0; wb_alu_result = 32'hFFFF;
    cycle();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_pipe: got we=%b exp 0", rf_we); end
    idle();
    mdu_valid = 1; mdu_rd = 0; mdu_data = $urandom;
    we_seen = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      mdu_valid = 0;
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL x0_model c%0d: got %h exp %h", c, act_v, exp_v); end
      we_seen |= rf_we;
    end
    checks++;
    if (we_seen !== 1'b0) begin errors++; $display("FAIL x0_mdu: got we=%b exp 0", we_seen); end
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
    lat = -1;
    for (int c = 1; c <= 3; c++) begin
      cycle();
      mdu_valid = 0;
      if (rf_we && lat < 0) lat = (rf_waddr == 9) ? c : 100;
    end
    checks++;
    if (lat != EXP_LAT) begin errors++; $display("FAIL x0_popped: got lat=%0d exp %0d", lat, EXP_LAT); end
  endtask

  task automatic test_reset_mid();
    logic we_any, rdy_all;
    idle();
    wb_valid = 1; wb_reg_write = 1; wb_rd = 3;
    for (int c = 0; c < 4; c++) begin
      wb_alu_result = $urandom;
      mdu_valid = (c < 2); mdu_rd = 5'(24 + c); mdu_data = $urandom;
      cycle();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL rmid_model c%0d: got %h exp %h", c, act_v, exp_v); end
    end
    reset = 1; mdu_valid = 1; mdu_rd = 26;
    cycle();
    checks++;
    if ({a_ready, a_stall, rf_we} !== 3'b000) begin
      errors++; $display("FAIL rmid_during: got %b exp 000", {a_ready, a_stall, rf_we});
    end
    idle();
    we_any = 0; rdy_all = 1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL rmid_after c%0d: got %h exp %h", c, act_v, exp_v); end
      we_any |= rf_we; rdy_all &= a_ready;
    end
    checks++;
    if ({we_any, rdy_all} !== 2'b01) begin
      errors++; $display("FAIL rmid_clean: got we=%b ready=%b exp we=0 ready=1", we_any, rdy_all);
    end
  endtask

  task automatic test_random();
    bit hold_wb, hold_mdu;
    idle();
    hold_wb = 0; hold_mdu = 0;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      if (!hold_wb) begin
        wb_valid = ($urandom_range(0, 9) < 7); wb_reg_write = ($urandom_range(0, 9) < 8);
        wb_result_src = result_src_t'($urandom_range(0, 2)); wb_rd = 5'($urandom);
        wb_alu_result = $urandom; wb_read_data = $urandom; wb_pc_plus_4 = $urandom;
      end
      if (!hold_mdu) begin
        mdu_valid = ($urandom_range(0, 2) == 0); mdu_rd = 5'($urandom); mdu_data = $urandom;
      end
      cycle();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL random c%0d: got %h exp %h", c, act_v, exp_v); end
      hold_wb = a_stall;
      hold_mdu = mdu_valid && !a_ready && !reset;
    end
    idle();
    cycle();
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_pipeline_only();
    test_mdu_only();
    test_starvation();
    test_fifo_full();
    test_x0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
